wb_block_reader: RTL and testbench

Wishbone initiator that reads a contiguous block of words from a Wishbone responder (the on-chip frame memory) and presents them as a flow-controlled stream to downstream LED pixel logic. A start command carries a base word address and a length. The block issues single read cycles compatible with the memory's registered-ack behaviour and buffers returned words in a small FIFO. It then signals completion once the last word has left the stream port.

---
 rtl/wb_block_reader.sv | 226 ++++++++++++++++++++++
 tb/tb_wb_block_reader.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_block_reader.sv
// wb_block_reader: Wishbone read initiator that fetches a contiguous block of
// words from the frame memory and hands them to the pixel logic as a stream.
//
// One single read is in flight at a time. Every acknowledged cycle is followed
// by one strobe-low GAP cycle because the responder's ack is registered.
// A request is only issued when the FIFO has a free slot.
//
// Optional feature: define WB_BLOCK_READER_TIMEOUT_EN to abort a block when
// ack is missing for 255 consecutive REQ cycles. In that case error and done
// pulse together. Without the macro, REQ waits forever and error is tied low.
//
// Handshakes:
//   - Wishbone: wbm_cycle == wbm_strobe. A read completes in a cycle where
//     strobe and ack are both high.
//   - Stream: a word transfers at a rising edge when stream_valid and
//     stream_ready are both high. stream_data holds the head word while
//     stream_valid is high and is 0 otherwise.
module wb_block_reader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] wbm_address,
    output logic [DATA_WIDTH-1:0] wbm_writedata,
    input  logic [DATA_WIDTH-1:0] wbm_readdata,
    output logic                  wbm_strobe,
    output logic                  wbm_cycle,
    output logic                  wbm_write,
    input  logic                  wbm_ack,
    output logic [DATA_WIDTH-1:0] stream_data,
    output logic                  stream_valid,
    input  logic                  stream_ready,
    output logic [2:0]            dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_REQ        = 3'd1,
        S_GAP        = 3'd2,
        S_WAIT_SPACE = 3'd3,
        S_DRAIN      = 3'd4,
        S_FIN        = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  issued_q, issued_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
    logic                  push;
    logic                  pop;
    logic                  flush;

    // A read completes only while we are strobing; stale acks in GAP are ignored.
    assign push = (state_q == S_REQ) && wbm_ack;
    assign pop  = (count_q != '0) && stream_ready;

`ifdef WB_BLOCK_READER_TIMEOUT_EN
    logic [7:0] timer_q, timer_d;
    logic       timeout_q, timeout_d;

    // The 255th consecutive REQ cycle without ack aborts the block.
    assign flush = (state_q == S_REQ) && !wbm_ack && (timer_q == 8'd254);
    assign error = (state_q == S_FIN) && timeout_q;

    // Count unacknowledged REQ cycles; remember a timeout until FIN.
    always_comb begin
        timer_d   = 8'd0;
        timeout_d = timeout_q;
        if ((state_q == S_REQ) && !wbm_ack && !flush) begin
            timer_d = timer_q + 8'd1;
        end
        if (flush) begin
            timeout_d = 1'b1;
        end else if (state_q == S_FIN) begin
            timeout_d = 1'b0;
        end
    end

    // Timeout registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q   <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end
`else
    assign flush = 1'b0;
    assign error = 1'b0;
`endif

    // FIFO occupancy and pointers; a timeout flush empties the buffer.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Next-state logic. FIN is entered on the same edge that empties the FIFO,
    // so done follows the last stream transfer by exactly one cycle.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        issued_d = issued_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    len_d    = length;
                    issued_d = '0;
                    state_d  = (length == '0) ? S_FIN : S_REQ;
                end
            end
            S_REQ: begin
                if (wbm_ack) begin
                    issued_d = issued_q + 1'b1;
                    state_d  = S_GAP;
                end else if (flush) begin
                    state_d = S_FIN;
                end
            end
            S_GAP: begin
                if (issued_q == len_q) begin
                    state_d = (count_d == '0) ? S_FIN : S_DRAIN;
                end else if (count_q != DEPTH_C) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_WAIT_SPACE;
                end
            end
            S_WAIT_SPACE: begin
                if (count_q != DEPTH_C) begin
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (count_d == '0) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and FIFO bookkeeping registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage needs no reset: stream_data is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= wbm_readdata;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_FIN);
    assign wbm_strobe    = (state_q == S_REQ);
    assign wbm_cycle     = wbm_strobe;
    assign wbm_write     = 1'b0;
    assign wbm_writedata = '0;
    assign wbm_address   = wbm_strobe ? (base_q + ADDR_WIDTH'(issued_q)) : '0;
    assign stream_valid  = (count_q != '0);
    assign stream_data   = stream_valid ? fifo_mem_q[rd_ptr_q] : '0;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_wb_block_reader.sv
// Bench for wb_block_reader: responder memory with registered ack and data,
// table of block reads with hand-computed results, and sequences for
// back-pressure, start-while-busy, reset mid-burst and (optionally) timeout.
module tb_wb_block_reader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] length;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] wbm_address;
    logic [31:0] wbm_writedata;
    logic [31:0] wbm_readdata;
    logic        wbm_strobe;
    logic        wbm_cycle;
    logic        wbm_write;
    logic        wbm_ack;
    logic [31:0] stream_data;
    logic        stream_valid;
    logic        stream_ready;
    logic [2:0]  dbg_state;

    wb_block_reader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .wbm_address  (wbm_address),
        .wbm_writedata(wbm_writedata),
        .wbm_readdata (wbm_readdata),
        .wbm_strobe   (wbm_strobe),
        .wbm_cycle    (wbm_cycle),
        .wbm_write    (wbm_write),
        .wbm_ack      (wbm_ack),
        .stream_data  (stream_data),
        .stream_valid (stream_valid),
        .stream_ready (stream_ready),
        .dbg_state    (dbg_state)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Responder memory contents
    function automatic logic [31:0] memval(input logic [15:0] a);
        if (a >= 16'h0100 && a <= 16'h0103) begin
            return 32'h0000_00A0 + {16'h0000, a - 16'h0100};
        end
        return {16'hBEEF, a};
    endfunction

    // Responder: ack and data registered one cycle after the strobe
    logic force_nack;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            wbm_ack      <= 1'b0;
            wbm_readdata <= 32'h0;
        end else begin
            wbm_ack      <= wbm_cycle & wbm_strobe & ~force_nack;
            wbm_readdata <= memval(wbm_address);
        end
    end

    // Scoreboard state
    logic [31:0] exp_q[$];
    logic [15:0] addr_q[$];
    int checks;
    int errors;
    int tick_cnt;
    int rmode;
    logic [7:0] rpat;
    int stb_cnt;
    int reads_cnt;
    int done_cnt;
    int err_cnt;
    bit prev_ack_stb;
    bit last_done;
    bit last_error;
    int lat;
    bit got;
    int r0;
    int s0;
    int d0;
    bit found;

    typedef struct {
        logic [15:0] base;
        logic [15:0] len;
        int          rmode;
        int          exp_lat;
        int          exp_reads;
        int          exp_stb;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: sample outputs at the falling edge, then drive stream_ready
    // for the coming rising edge and score any transfer it will perform.
    task automatic tick();
        @(negedge clk);
        tick_cnt++;
        case (rmode)
            0:       stream_ready = 1'b1;
            1:       stream_ready = 1'b0;
            default: stream_ready = rpat[tick_cnt[2:0]];
        endcase
        check("cyc_eq_stb", {63'd0, wbm_cycle}, {63'd0, wbm_strobe});
        check("wb_write_zero", {31'd0, wbm_write, wbm_writedata}, 64'd0);
        if (prev_ack_stb) check("gap_after_ack", {63'd0, wbm_strobe}, 64'd0);
        if (wbm_strobe) stb_cnt++;
        if (wbm_strobe && wbm_ack) begin
            reads_cnt++;
            if (addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_addr: got unexpected read at %0h expected none", wbm_address);
            end else begin
                check("rd_addr", {48'd0, wbm_address}, {48'd0, addr_q.pop_front()});
            end
        end
        prev_ack_stb = wbm_strobe && wbm_ack;
        if (stream_valid && stream_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stream_word: got unexpected %0h expected none", stream_data);
            end else begin
                check("stream_word", {32'd0, stream_data}, {32'd0, exp_q.pop_front()});
            end
        end
        if (done) done_cnt++;
        if (error) err_cnt++;
        last_done  = done;
        last_error = error;
    endtask

    // Driver: queue expectations and raise start for one cycle.
    task automatic start_cmd(input logic [15:0] b, input logic [15:0] n);
        logic [15:0] a;
        for (int i = 0; i < int'(n); i++) begin
            a = b + 16'(i);
            exp_q.push_back(memval(a));
            addr_q.push_back(a);
        end
        start     = 1'b1;
        base_addr = b;
        length    = n;
    endtask

    task automatic wait_done(input int budget, output int l, output bit g);
        g = 1'b0;
        l = 0;
        for (int i = 0; i < budget && !g; i++) begin
            tick();
            start = 1'b0;
            l++;
            if (last_done) g = 1'b1;
        end
        check("done_seen", {63'd0, g}, 64'd1);
    endtask

    task automatic run_vec(input vec_t v);
        r0    = reads_cnt;
        s0    = stb_cnt;
        d0    = done_cnt;
        rmode = v.rmode;
        start_cmd(v.base, v.len);
        wait_done(300, lat, got);
        if (v.exp_lat >= 0) check("latency", 64'(lat), 64'(v.exp_lat));
        check("busy_in_fin", {63'd0, busy}, 64'd1);
        check("error_at_done", {63'd0, last_error}, 64'd0);
        tick();
        check("busy_after_done", {63'd0, busy}, 64'd0);
        check("reads", 64'(reads_cnt - r0), 64'(v.exp_reads));
        check("strobe_cycles", 64'(stb_cnt - s0), 64'(v.exp_stb));
        check("done_pulses", 64'(done_cnt - d0), 64'd1);
        check("words_left", 64'(exp_q.size()), 64'd0);
        check("addrs_left", 64'(addr_q.size()), 64'd0);
    endtask

    initial begin
        checks = 0; errors = 0; tick_cnt = 0; rmode = 0; rpat = 8'b1011_0010;
        stb_cnt = 0; reads_cnt = 0; done_cnt = 0; err_cnt = 0;
        prev_ack_stb = 1'b0; last_done = 1'b0; last_error = 1'b0;
        reset = 1'b0; start = 1'b0; base_addr = 16'h0; length = 16'h0;
        stream_ready = 1'b1; force_nack = 1'b0;

        vecs[0] = '{base: 16'h0100, len: 16'd4, rmode: 0, exp_lat: 13, exp_reads: 4, exp_stb: 8};
        vecs[1] = '{base: 16'hFFFE, len: 16'd4, rmode: 0, exp_lat: 13, exp_reads: 4, exp_stb: 8};
        vecs[2] = '{base: 16'h0200, len: 16'd0, rmode: 0, exp_lat: 1,  exp_reads: 0, exp_stb: 0};
        vecs[3] = '{base: 16'h0300, len: 16'd1, rmode: 0, exp_lat: 4,  exp_reads: 1, exp_stb: 2};
        vecs[4] = '{base: 16'h0040, len: 16'd7, rmode: 2, exp_lat: -1, exp_reads: 7, exp_stb: 14};
        vecs[5] = '{base: 16'h1234, len: 16'd9, rmode: 0, exp_lat: 28, exp_reads: 9, exp_stb: 18};

        // Reset state
        tick();
        tick();
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_error", {63'd0, error}, 64'd0);
        check("rst_strobe", {63'd0, wbm_strobe}, 64'd0);
        check("rst_valid", {63'd0, stream_valid}, 64'd0);
        check("rst_address", {48'd0, wbm_address}, 64'd0);
        check("rst_stream_data", {32'd0, stream_data}, 64'd0);
        check("rst_state", {61'd0, dbg_state}, 64'd0);
        reset = 1'b1;
        tick();

        // Table of complete blocks
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Back-pressure: FIFO fills after 4 reads, then bus stays quiet
        rmode = 1;
        r0 = reads_cnt;
        d0 = done_cnt;
        start_cmd(16'h0800, 16'd10);
        tick();
        start = 1'b0;
        repeat (40) tick();
        check("bp_reads_held", 64'(reads_cnt - r0), 64'd4);
        check("bp_strobe_low", {63'd0, wbm_strobe}, 64'd0);
        check("bp_valid", {63'd0, stream_valid}, 64'd1);
        check("bp_busy", {63'd0, busy}, 64'd1);
        s0 = stb_cnt;
        repeat (10) tick();
        check("bp_no_strobe", 64'(stb_cnt - s0), 64'd0);
        rmode = 0;
        wait_done(300, lat, got);
        check("bp_reads_total", 64'(reads_cnt - r0), 64'd10);
        check("bp_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("bp_words_left", 64'(exp_q.size()), 64'd0);
        tick();

        // Start while busy is ignored
        d0 = done_cnt;
        r0 = reads_cnt;
        start_cmd(16'h0500, 16'd5);
        repeat (3) begin
            tick();
            start = 1'b0;
        end
        start     = 1'b1;
        base_addr = 16'h0900;
        length    = 16'd2;
        tick();
        start = 1'b0;
        wait_done(300, lat, got);
        repeat (6) tick();
        check("sb_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("sb_reads", 64'(reads_cnt - r0), 64'd5);
        check("sb_words_left", 64'(exp_q.size()), 64'd0);

        // Reset during the third word's REQ
        r0 = reads_cnt;
        start_cmd(16'h0A00, 16'd6);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            start = 1'b0;
            if ((reads_cnt - r0) == 2 && wbm_strobe) found = 1'b1;
        end
        check("reached_third_req", {63'd0, found}, 64'd1);
        reset = 1'b0;
        #1;
        check("ar_strobe", {63'd0, wbm_strobe}, 64'd0);
        check("ar_busy", {63'd0, busy}, 64'd0);
        check("ar_valid", {63'd0, stream_valid}, 64'd0);
        check("ar_stream_data", {32'd0, stream_data}, 64'd0);
        exp_q.delete();
        addr_q.delete();
        tick();
        tick();
        reset = 1'b1;
        prev_ack_stb = 1'b0;
        s0 = stb_cnt;
        repeat (5) tick();
        check("ar_bus_quiet", 64'(stb_cnt - s0), 64'd0);
        run_vec(vecs[0]);

`ifdef WB_BLOCK_READER_TIMEOUT_EN
        // Responder never acknowledges
        force_nack = 1'b1;
        s0 = stb_cnt;
        start     = 1'b1;
        base_addr = 16'h0700;
        length    = 16'd3;
        wait_done(400, lat, got);
        check("to_strobe_cycles", 64'(stb_cnt - s0), 64'd255);
        check("to_latency", 64'(lat), 64'd256);
        check("to_error", {63'd0, last_error}, 64'd1);
        tick();
        check("to_busy_after", {63'd0, busy}, 64'd0);
        check("to_valid_after", {63'd0, stream_valid}, 64'd0);
        force_nack = 1'b0;
        run_vec(vecs[3]);
        check("error_pulses", 64'(err_cnt), 64'd1);
`else
        check("error_pulses", 64'(err_cnt), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
